fifo_rd_stream: RTL

Read-side consumer for the async FIFO. It runs in the read clock domain and drives rd_rq against the FIFO's empty/rdata read port. It converts that read port into a valid/ready stream with a 2-entry output buffer, so a stalled downstream never loses a word and an unstalled one sustains 1 word/cycle. It also counts delivered words.

---
 rtl/fifo_rd_stream.sv | 116 +++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the async FIFO: turns the FIFO read port into a
// valid/ready stream through a 2-entry head/skid buffer and counts delivered words.
module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             r_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rd_rq,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             busy
);

  logic             run_r;
  logic [1:0]       occ_r;
  logic             inflight_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] skid_r;
  logic [CNT_W-1:0] cnt_r;

  logic             pop_s;
  logic [1:0]       committed_s;
  logic             rd_rq_s;
  logic [1:0]       occ_s;
  logic [WIDTH-1:0] head_s;
  logic [WIDTH-1:0] skid_s;

  // Read request: only issue when the word's slot is guaranteed after this cycle's pop.
  always_comb begin
    pop_s       = (occ_r != 2'd0) & m_ready;
    // pop implies occ >= 1, so the subtraction cannot underflow; result is 0..2
    committed_s = occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
    if (run_r & en & ~empty & (committed_s < 2'd2)) begin
      rd_rq_s = 1'b1;
    end else begin
      rd_rq_s = 1'b0;
    end
  end

  // Buffer next state: capture of the in-flight word and/or pop of the head.
  always_comb begin
    occ_s  = occ_r;
    head_s = head_r;
    skid_s = skid_r;
    case ({inflight_r, pop_s})
      2'b10: begin
        case (occ_r)
          2'd0:    head_s = rdata;
          2'd1:    skid_s = rdata;
          default: skid_s = skid_r;
        endcase
        if (occ_r != 2'd2) begin
          occ_s = occ_r + 2'd1;
        end else begin
          occ_s = occ_r;
        end
      end
      2'b11: begin
        if (occ_r == 2'd1) begin
          head_s = rdata;
        end else begin
          head_s = skid_r;
          skid_s = rdata;
        end
      end
      2'b01: begin
        head_s = skid_r;
        occ_s  = occ_r - 2'd1;
      end
      default: begin
        occ_s  = occ_r;
      end
    endcase
  end

  // run_r holds off reads until the first edge after reset release.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r      <= 1'b0;
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      head_r     <= '0;
      skid_r     <= '0;
    end else begin
      run_r      <= 1'b1;
      occ_r      <= occ_s;
      inflight_r <= rd_rq_s;
      head_r     <= head_s;
      skid_r     <= skid_s;
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (pop_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign rd_rq    = rd_rq_s;
  assign m_valid  = (occ_r != 2'd0);
  assign m_data   = head_r;
  assign xfer_cnt = cnt_r;
  assign busy     = (occ_r != 2'd0) | inflight_r;

endmodule
